// File: rtl/prog_loader.sv
// Byte-serial program loader: assembles strobed pin bytes into instruction words,
// writes them to instruction memory and holds the core in reset while loading.
module prog_loader #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        data_in,
    input  logic              strobe,
    input  logic              load_mode,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WIDTH-1:0]  imem_wdata,
    output logic              cpu_rst,
    output logic              byte_ack,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow
);

    localparam int BPW   = WIDTH / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BPW - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W:0]   MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_FULL,
        S_RELEASE
    } state_t;

    state_t             r_state;
    logic               r_stb_s1, r_stb_s2, r_stb_s3;
    logic               r_lm_s1, r_lm_s2;
    logic [IDX_W-1:0]   r_idx;
    logic               r_rel;
    logic [WIDTH-1:0]   r_word;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_cpu_rst;
    logic               r_ack;
    logic [ADDR_W:0]    r_count;
    logic               r_ovf;

    logic               w_stb_edge;
    logic               w_lm;

    // A held strobe produces a single edge; s3 only exists for edge detection.
    assign w_stb_edge = r_stb_s2 & ~r_stb_s3;
    assign w_lm       = r_lm_s2;

    function automatic logic [WIDTH-1:0] put_lane(input logic [WIDTH-1:0] word,
                                                  input logic [IDX_W-1:0] idx,
                                                  input logic [7:0]       b);
        logic [WIDTH-1:0] w;
        w = word;
        for (int i = 0; i < BPW; i++) begin
            if (IDX_W'(i) == idx) w[i*8 +: 8] = b;
        end
        return w;
    endfunction

    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c);
        return (c == MAX_COUNT) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_stb_s1  <= 1'b0;
            r_stb_s2  <= 1'b0;
            r_stb_s3  <= 1'b0;
            r_lm_s1   <= 1'b0;
            r_lm_s2   <= 1'b0;
            r_idx     <= '0;
            r_rel     <= 1'b0;
            r_word    <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_cpu_rst <= 1'b1;
            r_ack     <= 1'b0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_stb_s1 <= strobe;
            r_stb_s2 <= r_stb_s1;
            r_stb_s3 <= r_stb_s2;
            r_lm_s1  <= load_mode;
            r_lm_s2  <= r_lm_s1;
            r_we     <= 1'b0;
            r_ack    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_lm) begin
                        r_state   <= S_LOAD;
                        r_cpu_rst <= 1'b1;
                        r_addr    <= '0;
                        r_idx     <= '0;
                        r_count   <= '0;
                        r_ovf     <= 1'b0;
                    end else begin
                        r_cpu_rst <= 1'b0;
                    end
                end

                // FULL keeps assembling so the host sees acks, but never writes.
                S_LOAD, S_FULL: begin
                    if (!w_lm) begin
                        r_state <= S_RELEASE;
                        r_rel   <= 1'b0;
                        r_idx   <= '0;
                    end else if (w_stb_edge) begin
                        r_word <= put_lane(r_word, r_idx, data_in);
                        r_ack  <= 1'b1;
                        if (r_idx == LAST_IDX) begin
                            r_idx <= '0;
                            if (r_state == S_LOAD) begin
                                r_state <= S_WRITE;
                                r_we    <= 1'b1;
                            end else begin
                                r_ovf <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end

                S_WRITE: begin
                    r_count <= sat_inc(r_count);
                    r_rel   <= 1'b0;
                    if (r_addr == LAST_ADDR) begin
                        r_state <= w_lm ? S_FULL : S_RELEASE;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= w_lm ? S_LOAD : S_RELEASE;
                    end
                end

                S_RELEASE: begin
                    if (r_rel) begin
                        r_state   <= S_IDLE;
                        r_cpu_rst <= 1'b0;
                    end else begin
                        r_rel <= 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_word;
    assign cpu_rst    = r_cpu_rst;
    assign byte_ack   = r_ack;
    assign word_count = r_count;
    assign overflow   = r_ovf;

endmodule
